io_uart_tx: RTL



---
 rtl/lib_uart.sv | 15 +
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/io_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lib_uart.sv
// Shared UART definitions: frame geometry and the bit-level state encoding
// used by both the transmitter and the future receiver.
package lib_uart;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter. It holds at zero when not reloaded.
// tick marks the last cycle of the current bit period.
module uart_baud_cnt #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         tick
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tick = (count == '0);

endmodule

// File: rtl/io_uart_tx.sv
// Write-I/O UART transmitter: one holding register plus a shifter, 8N1 framing.
// w_busy reflects the holding register only, so the core can queue during a frame.
module io_uart_tx
   import lib_uart::*;
#(
   parameter int DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       w_req,
   input  logic [7:0] w_data,
   output logic       w_busy,
   output logic       uart_tx
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2) begin : g_div_check
         $error("io_uart_tx: DIV must be >= 2");
      end
   endgenerate

   uart_state_e state, state_next;
   logic [7:0]  hold, hold_next;
   logic [7:0]  shift, shift_next;
   logic [2:0]  idx, idx_next;
   logic        busy_next;
   logic        tx_next;
   logic        xfer;
   logic        load;
   logic        tick;
   logic [CW-1:0] count;

   uart_baud_cnt #(.W(CW)) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (CW'(DIV - 1)),
      .count    (count),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         shift   <= '0;
         idx     <= '0;
         w_busy  <= 1'b0;
         uart_tx <= 1'b1;
      end else begin
         state   <= state_next;
         hold    <= hold_next;
         shift   <= shift_next;
         idx     <= idx_next;
         w_busy  <= busy_next;
         uart_tx <= tx_next;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold;
      shift_next = shift;
      idx_next   = idx;
      busy_next  = w_busy;
      xfer       = 1'b0;
      load       = 1'b0;
      tx_next    = 1'b1;

      case (state)
         IDLE: begin
            if (w_busy) begin
               xfer       = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (tick) begin
               state_next = DATA;
               idx_next   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shift_next = shift >> 1;
               idx_next   = idx + 3'd1;
               if (idx == 3'(UART_DATA_BITS - 1)) state_next = STOP;
            end
         end
         STOP: begin
            // Refill on the stop-bit end edge keeps back-to-back frames gapless.
            if (tick) begin
               if (w_busy) begin
                  xfer       = 1'b1;
                  state_next = START;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      load = (state_next != IDLE) && ((state == IDLE) || tick);

      // A write arriving while the holding register is being freed is dropped.
      if (xfer) begin
         shift_next = hold;
         busy_next  = 1'b0;
      end else if (w_req && !w_busy) begin
         hold_next = w_data;
         busy_next = 1'b1;
      end

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

endmodule
